// File: rtl/muldiv_scheduler.sv
// Sequencer for the multi-cycle multiply/divide units: issues start pulses, times the run,
// and commits HI/LO. Optional MULDIV_EARLY_ZERO_EN short-circuits divide-by-zero from IDLE.
module muldiv_scheduler #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic req_mult,
   input  logic req_div,
   input  logic b_zero,
   input  logic flush,
   output logic mult_start,
   output logic div_start,
   output logic sel_div,
   output logic hi_we,
   output logic lo_we,
   output logic busy,
   output logic done,
   output logic div_zero_exc
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      WB       = 3'd3,
      DZ       = 3'd4
   } state_t;

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       zero_q;
   logic       sel_div_q;
   logic       mult_start_q;
   logic       div_start_q;
   logic       hi_we_q;
   logic       lo_we_q;
   logic       busy_q;
   logic       done_q;
   logic       dz_q;

   // State, run counter and all outputs; outputs are computed for the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         zero_q       <= 1'b0;
         sel_div_q    <= 1'b0;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         hi_we_q      <= 1'b0;
         lo_we_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dz_q         <= 1'b0;
      end else begin
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         hi_we_q      <= 1'b0;
         lo_we_q      <= 1'b0;
         done_q       <= 1'b0;
         dz_q         <= 1'b0;
         if (flush) begin
            // A kill never commits HI/LO and drops any request seen in the same cycle.
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (req_mult) begin
                     state_q      <= MULT_RUN;
                     cnt_q        <= 8'(MULT_CYCLES - 1);
                     sel_div_q    <= 1'b0;
                     mult_start_q <= 1'b1;
                     busy_q       <= 1'b1;
                  end else if (req_div) begin
                     sel_div_q <= 1'b1;
                     busy_q    <= 1'b1;
`ifdef MULDIV_EARLY_ZERO_EN
                     zero_q    <= 1'b0;
                     if (b_zero) begin
                        state_q <= DZ;
                        dz_q    <= 1'b1;
                     end else begin
                        state_q     <= DIV_RUN;
                        cnt_q       <= 8'(DIV_CYCLES - 1);
                        div_start_q <= 1'b1;
                     end
`else
                     zero_q      <= b_zero;
                     state_q     <= DIV_RUN;
                     cnt_q       <= 8'(DIV_CYCLES - 1);
                     div_start_q <= 1'b1;
`endif
                  end else begin
                     busy_q <= 1'b0;
                  end
               end
               MULT_RUN, DIV_RUN: begin
                  if (cnt_q == 8'd0) begin
                     if ((state_q == DIV_RUN) && zero_q) begin
                        state_q <= DZ;
                        dz_q    <= 1'b1;
                     end else begin
                        state_q <= WB;
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
               WB, DZ: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= 8'd0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mult_start   = mult_start_q;
   assign div_start    = div_start_q;
   assign sel_div      = sel_div_q;
   assign hi_we        = hi_we_q;
   assign lo_we        = lo_we_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign div_zero_exc = dz_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Table-driven bench for muldiv_scheduler: each record issues one request, optionally injects
// a disturbance mid-run, and a scoreboard of expected pulses is checked cycle by cycle.
module tb_muldiv_scheduler;

   logic clk = 1'b0;
   logic reset, req_mult, req_div, b_zero, flush;
   logic mult_start, div_start, sel_div, hi_we, lo_we, busy, done, div_zero_exc;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_scheduler #(.MULT_CYCLES(32), .DIV_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .req_mult(req_mult), .req_div(req_div), .b_zero(b_zero),
      .flush(flush), .mult_start(mult_start), .div_start(div_start), .sel_div(sel_div),
      .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .div_zero_exc(div_zero_exc)
   );

   always #5 clk = ~clk;

   // inj: 0 none, 1 req_div pulse, 2 flush, 3 async reset; inj_k 0 means together with the request
   typedef struct {
      string      name;
      logic       rm, rd, bz;
      int         inj_k;
      int         inj;
      int         start_k;
      logic [5:0] start_p;
      int         end_k;
      logic [5:0] end_p;
      int         busy_len;
      logic       sel;
   } vec_t;

   typedef struct {
      int         k;
      logic [5:0] p;
      logic       sel;
   } ev_t;

   vec_t tbl[$];
   ev_t  sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      ev_t        e;
      logic [5:0] pulses;
      int         busy_cnt;
      req_mult = v.rm;
      req_div  = v.rd;
      b_zero   = v.bz;
      if (v.inj == 2 && v.inj_k == 0) flush = 1'b1;
      if (v.start_k != 0) sbq.push_back('{v.start_k, v.start_p, v.sel});
      if (v.end_k != 0) sbq.push_back('{v.end_k, v.end_p, v.sel});
      @(posedge clk);
      #1;
      req_mult = 1'b0;
      req_div  = 1'b0;
      b_zero   = 1'b0;
      flush    = 1'b0;
      busy_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         pulses = {mult_start, div_start, hi_we, lo_we, done, div_zero_exc};
         if (busy) busy_cnt++;
         if (pulses != 6'b000000) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s spurious: pulses %b at cycle %0d, expected none", v.name, pulses, k);
            end else begin
               e = sbq.pop_front();
               chk({v.name, " cycle"}, k, e.k);
               chk({v.name, " pulses"}, 32'(pulses), 32'(e.p));
               chk({v.name, " sel_div"}, 32'(sel_div), 32'(e.sel));
            end
         end
         if (k == v.inj_k) begin
            case (v.inj)
               1: begin
                  req_div = 1'b1;
                  @(posedge clk);
                  #1;
                  req_div = 1'b0;
               end
               2: begin
                  flush = 1'b1;
                  @(posedge clk);
                  #1;
                  flush = 1'b0;
               end
               3: begin
                  reset = 1'b0;
                  #1;
                  chk({v.name, " async reset outputs"},
                      32'({mult_start, div_start, sel_div, hi_we, lo_we, busy, done, div_zero_exc}), 32'd0);
                  #2;
                  reset = 1'b1;
               end
               default: ;
            endcase
         end
      end
      chk({v.name, " missing pulses"}, sbq.size(), 0);
      sbq.delete();
      chk({v.name, " busy cycles"}, busy_cnt, v.busy_len);
      if (v.end_k != 0) chk({v.name, " sel_div held"}, 32'(sel_div), 32'(v.sel));
   endtask

   initial begin
      tbl.push_back('{"mult",          1'b1, 1'b0, 1'b0, 0,  0, 1, 6'b100000, 33, 6'b001110, 33, 1'b0});
      tbl.push_back('{"div",           1'b0, 1'b1, 1'b0, 0,  0, 1, 6'b010000, 33, 6'b001110, 33, 1'b1});
`ifdef MULDIV_EARLY_ZERO_EN
      tbl.push_back('{"div0",          1'b0, 1'b1, 1'b1, 0,  0, 0, 6'b000000, 1,  6'b000001, 1,  1'b1});
`else
      tbl.push_back('{"div0",          1'b0, 1'b1, 1'b1, 0,  0, 1, 6'b010000, 33, 6'b000001, 33, 1'b1});
`endif
      tbl.push_back('{"both",          1'b1, 1'b1, 1'b0, 0,  0, 1, 6'b100000, 33, 6'b001110, 33, 1'b0});
      tbl.push_back('{"both_bz",       1'b1, 1'b1, 1'b1, 0,  0, 1, 6'b100000, 33, 6'b001110, 33, 1'b0});
      tbl.push_back('{"no_req",        1'b0, 1'b0, 1'b0, 0,  0, 0, 6'b000000, 0,  6'b000000, 0,  1'b0});
      tbl.push_back('{"div_in_mult",   1'b1, 1'b0, 1'b0, 10, 1, 1, 6'b100000, 33, 6'b001110, 33, 1'b0});
      tbl.push_back('{"flush_mult",    1'b1, 1'b0, 1'b0, 5,  2, 1, 6'b100000, 0,  6'b000000, 5,  1'b0});
      tbl.push_back('{"flush_idle",    1'b0, 1'b1, 1'b0, 0,  2, 0, 6'b000000, 0,  6'b000000, 0,  1'b0});
      tbl.push_back('{"reset_div",     1'b0, 1'b1, 1'b0, 20, 3, 1, 6'b010000, 0,  6'b000000, 20, 1'b1});
      tbl.push_back('{"mult_after",    1'b1, 1'b0, 1'b0, 0,  0, 1, 6'b100000, 33, 6'b001110, 33, 1'b0});

      reset    = 1'b0;
      req_mult = 1'b0;
      req_div  = 1'b0;
      b_zero   = 1'b0;
      flush    = 1'b0;
      #23;
      chk("reset state outputs",
          32'({mult_start, div_start, sel_div, hi_we, lo_we, busy, done, div_zero_exc}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      foreach (tbl[i]) run_vec(tbl[i]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
